step_sequencer: RTL
===================

Name: step_sequencer

Overview:
- Instruction-level control sequencer; the consumer end of the processor's one-hot step counter.
- Accepts one instruction per valid/ready handshake and restarts the step counter.
- Decodes the counter's one-hot step vector into per-step datapath strobes for the register file, accumulator A, ALU result register G and the DIN bus driver.
- Reports completion (done) and protocol faults (err).

Parameters:
STEPS, 5, width of the one-hot step vector from the step counter; must be >= 3
RW, 3, register index width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered this cycle
instr_ready  out  1  sequencer can accept an instruction
instr_op  in  2  opcode: 00 LOAD, 01 MOVE, 10 ADD, 11 SUB
instr_rx  in  RW  destination / first-operand register index
instr_ry  in  RW  source / second-operand register index
step  in  STEPS  one-hot step vector from the step counter
step_restart  out  1  restart strobe to the step counter (counter shows bit0 next cycle)
wr_sel  out  RW  register index written when ctl_reg_in=1
rd_sel  out  RW  register index driven onto bus when ctl_reg_out=1
ctl_reg_in  out  1  write bus into register wr_sel
ctl_reg_out  out  1  drive register rd_sel onto bus
ctl_din_out  out  1  drive DIN onto bus
ctl_a_in  out  1  load A from bus
ctl_g_in  out  1  load G from ALU
ctl_g_out  out  1  drive G onto bus
alu_sub  out  1  ALU subtract (0 = add)
done  out  1  one-cycle completion pulse
err  out  1  sticky protocol-error flag

Behaviour:
- Reset is synchronous and active-high, applied at the clock edge. State becomes IDLE and the latched op/rx/ry become 0. Every output is 0 except instr_ready, which is 1.
- States: IDLE, EXEC, FINISH, ERROR. The latched op, rx and ry registers are written only on an accepted handshake.
- IDLE: instr_ready=1. When instr_valid=1 at cycle t:
  - step_restart=1 combinationally in cycle t.
  - op/rx/ry are latched at the t edge.
  - Next state is EXEC. At t+1 the step vector must equal bit0.
- instr_ready=0 in EXEC, FINISH and ERROR. instr_valid is ignored in those states and nothing is latched.
- EXEC: strobes are a combinational decode of state==EXEC, the latched op and the current step. Every strobe not listed below is 0.
  - LOAD, bit0 (last step): ctl_din_out=1, ctl_reg_in=1, wr_sel=rx.
  - MOVE, bit0 (last step): ctl_reg_out=1, rd_sel=ry, ctl_reg_in=1, wr_sel=rx.
  - ADD/SUB, bit0: ctl_reg_out=1, rd_sel=rx, ctl_a_in=1.
  - ADD/SUB, bit1: ctl_reg_out=1, rd_sel=ry, ctl_g_in=1; alu_sub = op[0].
  - ADD/SUB, bit2 (last step): ctl_g_out=1, ctl_reg_in=1, wr_sel=rx.
  - alu_sub = op[0] in every EXEC cycle of ADD/SUB; 0 otherwise.
- On the last step of the op, next state is FINISH.
- FINISH: all strobes 0; done=1 for exactly one cycle; next state is IDLE.
- Latency:
  - LOAD/MOVE: handshake at t, execute at t+1, done at t+2, ready at t+3.
  - ADD/SUB: execute t+1..t+3, done at t+4, ready at t+5.
- Error conditions in EXEC (go to ERROR next edge; strobes forced to 0 in that same cycle):
  - step is not one-hot (zero bits or more than one bit set);
  - step's set bit index is beyond the op's last step;
  - step's set bit index is below the expected index, i.e. the counter did not advance or restarted.
- ERROR: err=1; all strobes, done and step_restart are 0; instr_ready=0. Exits only via reset.
- step is not checked in IDLE or FINISH.
- Reset mid-operation: returns to IDLE at that edge; no done pulse; the latched instruction is discarded.
- When reset=1 and instr_valid=1 in the same cycle, reset wins: nothing is latched and step_restart=0.
- wr_sel/rd_sel show the latched rx/ry whenever the corresponding strobe is 0; they are don't-care for checking.

Test Plan:
- LOAD: reset, then valid with op=00, rx=3; counter responds bit0 at t+1. Expect step_restart=1 at t; at t+1 ctl_din_out=1, ctl_reg_in=1, wr_sel=3; done=1 at t+2; ready=1 at t+3.
- ADD: op=10, rx=1, ry=2; step = 00001, 00010, 00100. Expect:
  - t+1: reg_out with rd_sel=1, a_in;
  - t+2: reg_out with rd_sel=2, g_in, alu_sub=0;
  - t+3: g_out, reg_in with wr_sel=1;
  - done at t+4.
- SUB: same sequence with op=11. Expect alu_sub=1 at t+1..t+3; otherwise identical to ADD.
- Busy handshake: assert instr_valid continuously during the ADD. Expect instr_ready=0 at t+1..t+4, no second step_restart and latched op unchanged; second instruction accepted at t+5.
- Faults, each case from a fresh reset:
  - step=00011 in EXEC -> err=1 next cycle, strobes 0, stuck until reset;
  - MOVE with step=00010 at t+1 -> err=1;
  - ADD with step stuck at 00001 for two cycles -> err=1.
- Reset mid-ADD at t+2. Expect IDLE, ready=1 and all strobes 0 the next cycle, with no done pulse. Reset coincident with valid -> nothing latched, step_restart=0.

Source files
------------

// File: rtl/step_sequencer_if.sv
// Instruction handshake between the issuing stage (master) and the step sequencer (slave).
interface step_sequencer_if #(
   parameter int RW = 3
);
   logic          instr_valid;
   logic          instr_ready;
   logic [1:0]    instr_op;
   logic [RW-1:0] instr_rx;
   logic [RW-1:0] instr_ry;

   modport master (
      output instr_valid,
      output instr_op,
      output instr_rx,
      output instr_ry,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr_op,
      input  instr_rx,
      input  instr_ry,
      output instr_ready
   );
endinterface

// File: rtl/step_sequencer.sv
// Instruction-level control sequencer: accepts one instruction, restarts the one-hot
// step counter and decodes each step into datapath strobes; flags protocol faults.
module step_sequencer #(
   parameter int STEPS = 5,
   parameter int RW    = 3
) (
   input  logic             clock,
   input  logic             reset,
   step_sequencer_if.slave  instr,
   input  logic [STEPS-1:0] step,
   output logic             step_restart,
   output logic [RW-1:0]    wr_sel,
   output logic [RW-1:0]    rd_sel,
   output logic             ctl_reg_in,
   output logic             ctl_reg_out,
   output logic             ctl_din_out,
   output logic             ctl_a_in,
   output logic             ctl_g_in,
   output logic             ctl_g_out,
   output logic             alu_sub,
   output logic             done,
   output logic             err
);

   localparam int IW = $clog2(STEPS);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EXEC   = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;
   localparam logic [1:0] S_ERROR  = 2'd3;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_MOVE = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_SUB  = 2'b11;

   logic [1:0]    state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [RW-1:0] rx_q, rx_d;
   logic [RW-1:0] ry_q, ry_d;
   logic [IW-1:0] idx_q, idx_d;

   logic          step_onehot;
   logic [IW-1:0] step_idx;
   logic [IW-1:0] last_idx;
   logic          step_bad;
   logic          is_last;
   logic          accept;
   logic          exec_ok;

   // Step vector analysis: one-hot test plus index of the set bit.
   always_comb begin
      step_idx    = '0;
      step_onehot = (step != '0) && ((step & (step - STEPS'(1))) == '0);
      for (int unsigned i = 0; i < STEPS; i++) begin
         if (step[i]) begin
            step_idx = IW'(i);
         end
      end
   end

   assign last_idx = op_q[1] ? IW'(2) : '0;
   // Skipping forward within the op is tolerated; going backwards or past the end is not.
   assign step_bad = !step_onehot || (step_idx > last_idx) || (step_idx < idx_q);
   assign is_last  = step_onehot && (step_idx == last_idx);
   assign accept   = (state_q == S_IDLE) && instr.instr_valid;
   assign exec_ok  = (state_q == S_EXEC) && !step_bad;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rx_d    = rx_q;
      ry_d    = ry_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (instr.instr_valid) begin
               state_d = S_EXEC;
               op_d    = instr.instr_op;
               rx_d    = instr.instr_rx;
               ry_d    = instr.instr_ry;
               idx_d   = '0;
            end
         end
         S_EXEC: begin
            if (step_bad) begin
               state_d = S_ERROR;
            end else if (is_last) begin
               state_d = S_FINISH;
            end else begin
               idx_d = step_idx + IW'(1);
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_ERROR;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         rx_q    <= '0;
         ry_q    <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rx_q    <= rx_d;
         ry_q    <= ry_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      wr_sel      = rx_q;
      rd_sel      = ry_q;
      ctl_reg_in  = 1'b0;
      ctl_reg_out = 1'b0;
      ctl_din_out = 1'b0;
      ctl_a_in    = 1'b0;
      ctl_g_in    = 1'b0;
      ctl_g_out   = 1'b0;
      alu_sub     = 1'b0;
      if (exec_ok) begin
         case (op_q)
            OP_LOAD: begin
               ctl_din_out = 1'b1;
               ctl_reg_in  = 1'b1;
            end
            OP_MOVE: begin
               ctl_reg_out = 1'b1;
               ctl_reg_in  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
               alu_sub = op_q[0];
               case (step_idx)
                  IW'(0): begin
                     ctl_reg_out = 1'b1;
                     rd_sel      = rx_q;
                     ctl_a_in    = 1'b1;
                  end
                  IW'(1): begin
                     ctl_reg_out = 1'b1;
                     ctl_g_in    = 1'b1;
                  end
                  default: begin
                     ctl_g_out  = 1'b1;
                     ctl_reg_in = 1'b1;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   assign instr.instr_ready = (state_q == S_IDLE);
   assign step_restart      = accept && !reset;
   assign done              = (state_q == S_FINISH);
   assign err               = (state_q == S_ERROR);

endmodule
